// File: rtl/sram_rw_sequencer.sv
// SRAM request/response responder for one compute macro.
// Takes one read or write request at a time and steps the analog block
// through precharge, wordline (plus write drive) and sense-amp phases.
// Read data is captured from the sense amps and returned with a
// one-cycle valid pulse. All analog controls come straight from flops.
module sram_rw_sequencer #(
  parameter int unsigned numRows   = 128,
  parameter int unsigned numCols   = 32,
  parameter int unsigned pchCycles = 1,
  parameter int unsigned wlCycles  = 2,
  parameter int unsigned saCycles  = 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  // Digital request/response side
  input  logic                       rq_wr_i,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  input  logic [numCols-1:0]         wr_data_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  // Analog side
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic                       WRITE,
  output logic [numCols-1:0]         WR_DATA,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);

  localparam int unsigned AddrW   = $clog2(numRows);
  localparam int unsigned AddrWp1 = AddrW + 1;

  // One shared phase counter, wide enough for the longest phase.
  localparam int unsigned PwMax     = (pchCycles > wlCycles) ? pchCycles : wlCycles;
  localparam int unsigned MaxCycles = (PwMax > saCycles) ? PwMax : saCycles;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] PchLast = CntW'(pchCycles - 1);
  localparam logic [CntW-1:0] WlLast  = CntW'(wlCycles - 1);
  localparam logic [CntW-1:0] SaLast  = CntW'(saCycles - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  // One extra bit so numRows itself is representable for the range check.
  localparam logic [AddrW:0] RowLimit = AddrWp1'(numRows);

  typedef enum logic [2:0] {
    StIdle,
    StPrecharge,
    StWordline,
    StSense,
    StRespond
  } state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic                 req_wr_q;
  logic [AddrW-1:0]     req_addr_q;
  logic [numCols-1:0]   req_data_q;

  logic                 addr_in_range;
  logic [numRows-1:0]   wl_decode;

  // Ready is purely the idle state so it is already high during reset.
  assign rq_ready_o = (state_q == StIdle);

  // Only possible for non-power-of-two row counts; such rows get no wordline.
  assign addr_in_range = ({1'b0, req_addr_q} < RowLimit);

  // One-hot wordline pattern for the latched row.
  always_comb begin
    wl_decode = '0;
    if (addr_in_range) begin
      wl_decode[req_addr_q] = 1'b1;
    end
  end

  // Sequencer: state, phase counter, latched request and all registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      WL         <= '0;
      PCH        <= 1'b0;
      WRITE      <= 1'b0;
      WR_DATA    <= '0;
      CSEL       <= '0;
      SAEN       <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rq_valid_i) begin
            req_wr_q   <= rq_wr_i;
            req_addr_q <= addr_i;
            req_data_q <= wr_data_i;
            cnt_q      <= '0;
            PCH        <= 1'b1;
            state_q    <= StPrecharge;
          end
        end

        StPrecharge: begin
          if (cnt_q == PchLast) begin
            cnt_q   <= '0;
            PCH     <= 1'b0;
            WL      <= wl_decode;
            CSEL    <= '1;
            WRITE   <= req_wr_q;
            WR_DATA <= req_wr_q ? req_data_q : '0;
            state_q <= StWordline;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StWordline: begin
          if (cnt_q == WlLast) begin
            cnt_q   <= '0;
            WL      <= '0;
            WRITE   <= 1'b0;
            WR_DATA <= '0;
            if (req_wr_q) begin
              CSEL    <= '0;
              state_q <= StIdle;
            end else begin
              SAEN    <= 1'b1;
              state_q <= StSense;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StSense: begin
          if (cnt_q == SaLast) begin
            cnt_q      <= '0;
            SAEN       <= 1'b0;
            CSEL       <= '0;
            // No row was driven for an out-of-range address, so the amps hold garbage.
            rd_data_o  <= addr_in_range ? SA_OUT : '0;
            rd_valid_o <= 1'b1;
            state_q    <= StRespond;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StRespond: begin
          cnt_q      <= '0;
          rd_valid_o <= 1'b0;
          state_q    <= StIdle;
        end

        default: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rw_sequencer.sv
// Bench for sram_rw_sequencer: three instances (default timing, stretched
// timing, 100-row macro) share one stimulus stream. Each has an analog
// SRAM stand-in and a cycle-count model of the expected outputs.
module tb_sram_rw_sequencer;

  logic        clk;
  logic        nrst;
  logic        rq_wr;
  logic        rq_valid;
  logic [6:0]  addr;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  // Per-instance observed/expected outputs, bits {ready, pch, saen, write, rd_valid}.
  logic [4:0]   act_b    [3];
  logic [4:0]   exp_b    [3];
  logic [127:0] act_wl   [3];
  logic [127:0] exp_wl   [3];
  logic [31:0]  act_csel [3];
  logic [31:0]  exp_csel [3];
  logic [31:0]  act_wrd  [3];
  logic [31:0]  exp_wrd  [3];
  logic [31:0]  act_rdd  [3];
  logic [31:0]  exp_rdd  [3];

  bit          it_wr   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [6:0]  it_addr [6] = '{7'd0, 7'd0, 7'd127, 7'd127, 7'd0, 7'd127};
  logic [31:0] it_data [6] = '{32'h1111_0000, 32'h0, 32'h2222_7777, 32'h0,
                               32'h3333_0000, 32'h0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int Rows = (g == 2) ? 100 : 128;
    localparam int P    = (g == 1) ? 2 : 1;
    localparam int W    = (g == 1) ? 3 : 2;
    localparam int S    = (g == 1) ? 2 : 1;

    logic            rq_ready, rd_valid, pch, write, saen;
    logic [31:0]     rd_data, wr_drv, csel, sa_out;
    logic [Rows-1:0] wl;

    sram_rw_sequencer #(
      .numRows  (Rows),
      .numCols  (32),
      .pchCycles(P),
      .wlCycles (W),
      .saCycles (S)
    ) u_dut (
      .clk       (clk),
      .nrst      (nrst),
      .rq_wr_i   (rq_wr),
      .rq_valid_i(rq_valid),
      .rq_ready_o(rq_ready),
      .rd_valid_o(rd_valid),
      .rd_data_o (rd_data),
      .wr_data_i (wr_data),
      .addr_i    (addr),
      .WL        (wl),
      .PCH       (pch),
      .WRITE     (write),
      .WR_DATA   (wr_drv),
      .CSEL      (csel),
      .SAEN      (saen),
      .SA_OUT    (sa_out)
    );

    // Analog array stand-in: remembers the last selected row, garbage if none.
    logic [31:0] amem [Rows] = '{default: '0};
    int          sel_row = 0;
    bit          sel_ok  = 1'b0;
    always @(posedge clk) begin
      if (pch) sel_ok <= 1'b0;
      for (int i = 0; i < Rows; i++) begin
        if (wl[i]) begin
          sel_row <= i;
          sel_ok  <= 1'b1;
          if (write) amem[i] <= wr_drv;
        end
      end
    end
    assign sa_out = (saen && sel_ok) ? amem[sel_row] : 32'hDEAD_BEEF;

    // Model: m_n is the cycle number since the accepting edge.
    logic [31:0] mmem [Rows] = '{default: '0};
    bit          m_busy = 1'b0;
    bit          m_wr   = 1'b0;
    int          m_n    = 0;
    int          m_addr = 0;
    logic [31:0] m_data = '0;
    logic [31:0] m_rd   = '0;
    always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        m_busy <= 1'b0;
        m_n    <= 0;
        m_rd   <= '0;
      end else if (m_busy) begin
        m_n <= m_n + 1;
        if (m_n + 1 == (m_wr ? P + W + 1 : P + W + S + 2)) m_busy <= 1'b0;
        if (!m_wr && m_n + 1 == P + W + S + 1)
          m_rd <= (m_addr < Rows) ? mmem[m_addr] : '0;
      end else if (rq_valid) begin
        m_busy <= 1'b1;
        m_n    <= 1;
        m_wr   <= rq_wr;
        m_addr <= int'(addr);
        m_data <= wr_data;
        if (rq_wr && int'(addr) < Rows) mmem[addr] <= wr_data;
      end
    end

    logic [Rows-1:0] e_wl;
    logic            e_win, e_pch, e_saen, e_write, e_rdv;
    always_comb begin
      e_win   = m_busy && m_n > P && m_n <= P + W;
      e_pch   = m_busy && m_n >= 1 && m_n <= P;
      e_saen  = m_busy && !m_wr && m_n > P + W && m_n <= P + W + S;
      e_rdv   = m_busy && !m_wr && m_n == P + W + S + 1;
      e_write = e_win && m_wr;
      for (int i = 0; i < Rows; i++) e_wl[i] = e_win && (i == m_addr);
    end

    assign act_b[g]    = {rq_ready, pch, saen, write, rd_valid};
    assign exp_b[g]    = {!m_busy, e_pch, e_saen, e_write, e_rdv};
    assign act_wl[g]   = 128'(wl);
    assign exp_wl[g]   = 128'(e_wl);
    assign act_csel[g] = csel;
    assign exp_csel[g] = (e_win || e_saen) ? '1 : '0;
    assign act_wrd[g]  = wr_drv;
    assign exp_wrd[g]  = e_write ? m_data : '0;
    assign act_rdd[g]  = rd_data;
    assign exp_rdd[g]  = m_rd;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("u%0d.ready", g), act_b[g][4], exp_b[g][4]);
      chk($sformatf("u%0d.pch", g), act_b[g][3], exp_b[g][3]);
      chk($sformatf("u%0d.saen", g), act_b[g][2], exp_b[g][2]);
      chk($sformatf("u%0d.write", g), act_b[g][1], exp_b[g][1]);
      chk($sformatf("u%0d.rd_valid", g), act_b[g][0], exp_b[g][0]);
      chk($sformatf("u%0d.wl", g), act_wl[g], exp_wl[g]);
      chk($sformatf("u%0d.csel", g), act_csel[g], exp_csel[g]);
      chk($sformatf("u%0d.wr_data", g), act_wrd[g], exp_wrd[g]);
      chk($sformatf("u%0d.rd_data", g), act_rdd[g], exp_rdd[g]);
      chk($sformatf("u%0d.no_overlap", g),
          $countones({act_b[g][3], |act_wl[g], act_b[g][2]}) <= 1, 1'b1);
    end
  endtask

  // Advance one clock; return at the following falling edge after checking.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic goto(input int n);
    while (cur < n) begin
      tick();
      cur++;
    end
  endtask

  // Present a request for exactly one edge; returns at cycle 1 of it.
  task automatic req(input bit wr, input logic [6:0] a, input logic [31:0] d);
    rq_valid = 1'b1;
    rq_wr    = wr;
    addr     = a;
    wr_data  = d;
    tick();
    rq_valid = 1'b0;
    cur      = 1;
  endtask

  initial begin
    int idx;
    int rdv_cnt;
    bit acc;
    nrst     = 1'b0;
    rq_valid = 1'b0;
    rq_wr    = 1'b0;
    addr     = '0;
    wr_data  = '0;
    @(negedge clk);
    tick();
    tick();
    chk("reset.ready", act_b[0][4], 1'b1);
    chk("reset.rd_data", act_rdd[0], 32'h0);
    chk("reset.wl", act_wl[0], 128'h0);
    nrst = 1'b1;
    tick();

    // Write row 5
    req(1'b1, 7'd5, 32'hA5A5_0F0F);
    chk("wr.pch_c1", act_b[0][3], 1'b1);
    goto(2);
    chk("wr.wl5_c2", act_wl[0], 128'h1 << 5);
    chk("wr.write_c2", act_b[0][1], 1'b1);
    chk("wr.wrdata_c2", act_wrd[0], 32'hA5A5_0F0F);
    goto(4);
    chk("wr.ready_c4", act_b[0][4], 1'b1);
    goto(5);
    chk("wr.slow_ready_c5", act_b[1][4], 1'b0);
    goto(6);
    chk("wr.slow_ready_c6", act_b[1][4], 1'b1);
    goto(12);

    // Read row 5 back
    req(1'b0, 7'd5, 32'h0);
    goto(4);
    chk("rd.saen_c4", act_b[0][2], 1'b1);
    goto(5);
    chk("rd.valid_c5", act_b[0][0], 1'b1);
    chk("rd.data_c5", act_rdd[0], 32'hA5A5_0F0F);
    goto(6);
    chk("rd.ready_c6", act_b[0][4], 1'b1);
    chk("rd.data_hold_c6", act_rdd[0], 32'hA5A5_0F0F);
    goto(7);
    chk("rd.slow_valid_c7", act_b[1][0], 1'b0);
    goto(8);
    chk("rd.slow_valid_c8", act_b[1][0], 1'b1);
    chk("rd.slow_data_c8", act_rdd[1], 32'hA5A5_0F0F);
    goto(12);

    // Reset in the middle of a read
    req(1'b0, 7'd5, 32'h0);
    goto(3);
    nrst = 1'b0;
    #1;
    compare_all();
    chk("rst.wl", act_wl[0], 128'h0);
    chk("rst.slow_wl", act_wl[1], 128'h0);
    chk("rst.pch_saen", {act_b[0][3], act_b[0][2]}, 2'b00);
    chk("rst.ready", act_b[0][4], 1'b1);
    tick();
    tick();
    nrst = 1'b1;
    rdv_cnt = 0;
    repeat (10) begin
      tick();
      rdv_cnt += int'(act_b[0][0]);
    end
    chk("rst.no_rd_valid", rdv_cnt, 0);
    req(1'b0, 7'd5, 32'h0);
    goto(5);
    chk("rst.next_valid_c5", act_b[0][0], 1'b1);
    chk("rst.next_data_c5", act_rdd[0], 32'hA5A5_0F0F);
    goto(12);

    // Row 110: in range for 128 rows, out of range for 100 rows
    req(1'b1, 7'd110, 32'h1234_5678);
    goto(2);
    chk("oor.wr_wl_c2", act_wl[2], 128'h0);
    goto(12);
    req(1'b0, 7'd110, 32'h0);
    goto(3);
    chk("oor.rd_wl_c3", act_wl[2], 128'h0);
    goto(5);
    chk("oor.valid_c5", act_b[2][0], 1'b1);
    chk("oor.data_c5", act_rdd[2], 32'h0);
    chk("oor.inrange_data_c5", act_rdd[0], 32'h1234_5678);
    goto(12);

    // Back-to-back with valid held high, stepping on default instance's ready
    idx      = 0;
    rdv_cnt  = 0;
    rq_valid = 1'b1;
    rq_wr    = it_wr[0];
    addr     = it_addr[0];
    wr_data  = it_data[0];
    for (int c = 0; c < 200 && idx < 6; c++) begin
      acc = act_b[0][4];
      tick();
      rdv_cnt += int'(act_b[0][0]);
      if (acc) begin
        idx++;
        if (idx < 6) begin
          rq_wr   = it_wr[idx];
          addr    = it_addr[idx];
          wr_data = it_data[idx];
        end
      end
    end
    rq_valid = 1'b0;
    repeat (12) begin
      tick();
      rdv_cnt += int'(act_b[0][0]);
    end
    chk("b2b.accepted", idx, 6);
    chk("b2b.reads", rdv_cnt, 3);
    chk("b2b.last_data", act_rdd[0], 32'h2222_7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
